// File: rtl/rgba_to_gray_feeder.sv
// RGBA (16 px/line) to 8-bit luma feeder for the Sobel edge unit, two-stage pipeline.
// Build option GRAY_FLUSH_EN: append FLUSH_BEATS all-zero beats after each frame.
module rgba_to_gray_feeder #(
  parameter int unsigned FRAME_BEATS = 16384,
  parameter int unsigned FLUSH_BEATS = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(FRAME_BEATS + FLUSH_BEATS + 1);
`ifdef GRAY_FLUSH_EN
  localparam int unsigned TOTAL = FRAME_BEATS + FLUSH_BEATS;
  localparam logic [CW-1:0] FLUSH_N = CW'(FLUSH_BEATS);
`else
  localparam int unsigned TOTAL = FRAME_BEATS;
`endif
  localparam logic [CW-1:0] FRAME_N    = CW'(FRAME_BEATS);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] OUT_LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

`ifdef GRAY_FLUSH_EN
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
`else
  typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            done_q, done_d;
  logic            s1_valid_q, s1_valid_d;
  logic [15:0]     rp_q [16];
  logic [15:0]     gp_q [16];
  logic [15:0]     bp_q [16];
  logic [15:0]     rp_d [16];
  logic [15:0]     gp_d [16];
  logic [15:0]     bp_d [16];
  logic            out_valid_q, out_valid_d;
  logic [127:0]    out_data_q, out_data_d;
  logic            adv, accept, out_hs, final_hs, inject;
  logic            unused_alpha;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = (state_q == STREAM) & adv & (in_cnt_q < FRAME_N);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;
  assign final_hs = out_hs & (out_cnt_q == OUT_LAST);

`ifdef GRAY_FLUSH_EN
  logic [CW-1:0] fl_cnt_q, fl_cnt_d;
  assign inject = (state_q == FLUSH) & adv & (fl_cnt_q < FLUSH_N);
`else
  assign inject = 1'b0;
`endif

  // Start is also refused while done is high so a pulse in the done cycle cannot re-arm.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
`ifdef GRAY_FLUSH_EN
    fl_cnt_d  = fl_cnt_q;
    if (inject) fl_cnt_d = fl_cnt_q + ONE;
`endif
    if (accept) in_cnt_d  = in_cnt_q + ONE;
    if (out_hs) out_cnt_d = out_cnt_q + ONE;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d   = STREAM;
          in_cnt_d  = '0;
          out_cnt_d = '0;
`ifdef GRAY_FLUSH_EN
          fl_cnt_d  = '0;
`endif
        end
      end
`ifdef GRAY_FLUSH_EN
      STREAM: begin
        if (accept && (in_cnt_q == FRAME_LAST)) state_d = FLUSH;
      end
      FLUSH: begin
        if (final_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`else
      STREAM: begin
        if (final_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: per-pixel weighted products; flush lines load as zeros.
  always_comb begin
    s1_valid_d = s1_valid_q;
    for (int unsigned i = 0; i < 16; i++) begin
      rp_d[i] = rp_q[i];
      gp_d[i] = gp_q[i];
      bp_d[i] = bp_q[i];
    end
    if (adv) begin
      s1_valid_d = accept | inject;
      for (int unsigned i = 0; i < 16; i++) begin
        rp_d[i] = '0;
        gp_d[i] = '0;
        bp_d[i] = '0;
        if (accept) begin
          rp_d[i] = 16'(in_data[32*i      +: 8]) * 16'd77;
          gp_d[i] = 16'(in_data[32*i + 8  +: 8]) * 16'd150;
          bp_d[i] = 16'(in_data[32*i + 16 +: 8]) * 16'd29;
        end
      end
    end
  end

  // Stage 2: sum and keep the high byte; weights total 256 so no overflow.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      for (int unsigned i = 0; i < 16; i++)
        out_data_d[8*i +: 8] = 8'((rp_q[i] + gp_q[i] + bp_q[i]) >> 8);
    end
  end

  always_comb begin
    unused_alpha = 1'b0;
    for (int unsigned i = 0; i < 16; i++)
      unused_alpha = unused_alpha ^ (^in_data[32*i + 24 +: 8]);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef GRAY_FLUSH_EN
      fl_cnt_q    <= '0;
`endif
      for (int unsigned i = 0; i < 16; i++) begin
        rp_q[i] <= '0;
        gp_q[i] <= '0;
        bp_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef GRAY_FLUSH_EN
      fl_cnt_q    <= fl_cnt_d;
`endif
      for (int unsigned i = 0; i < 16; i++) begin
        rp_q[i] <= rp_d[i];
        gp_q[i] <= gp_d[i];
        bp_q[i] <= bp_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_rgba_to_gray_feeder.sv
// Directed bench for rgba_to_gray_feeder (FRAME_BEATS=4, FLUSH_BEATS=2); honours GRAY_FLUSH_EN.
module tb_rgba_to_gray_feeder;

`ifdef GRAY_FLUSH_EN
  localparam int TOTAL = 6;
`else
  localparam int TOTAL = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;
  logic         done;

  rgba_to_gray_feeder #(.FRAME_BEATS(4), .FLUSH_BEATS(2)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cnt = 0, beat_cnt = 0, done_cnt = 0;
  int lat_acc = -1, lat_out = -1, lat_done = -1;
  bit lat_arm = 1'b0, rnd_en = 1'b0;
  bit held_v = 1'b0;
  logic [127:0] held_d = '0;
  logic [511:0] lines [4];
  logic [127:0] beats [4];
  logic [127:0] exp_q [$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor samples mid-cycle; values seen here are what the next rising edge uses.
  always @(negedge clk) begin
    if (rst_b) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (lat_arm && lat_acc < 0) lat_acc = cyc;
      end
      if (held_v) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, held_d);
      end
      if (out_valid && lat_arm && lat_out < 0) lat_out = cyc;
      if (out_valid && out_ready) begin
        beat_cnt++;
        chk("beat_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("beat", out_data, exp_q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (done) begin
        done_cnt++;
        if (lat_arm && lat_done < 0) lat_done = cyc;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic push_exp();
    for (int i = 0; i < 4; i++) exp_q.push_back(beats[i]);
    for (int i = 4; i < TOTAL; i++) exp_q.push_back('0);
  endtask

  task automatic run_frame(input bit rnd, input bit poke);
    int a0, b0, d0, idx;
    bit fin, poked;
    a0 = acc_cnt; b0 = beat_cnt; d0 = done_cnt; fin = 0; poked = 0;
    push_exp();
    rnd_en = rnd;
    start = 1'b1; in_valid = 1'b1; in_data = lines[0];
    for (int t = 0; t < 1000 && !fin; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      idx = acc_cnt - a0;
      in_data = (idx < 4) ? lines[idx] : '0;
      if (done) begin
        fin = 1;
        if (poke) start = 1'b1;
      end else if (poke && !poked && idx == 2) begin
        start = 1'b1;
        poked = 1;
      end
    end
    chk("done_seen", fin, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; rnd_en = 1'b0;
    chk("accepts", 32'(acc_cnt - a0), 32'd4);
    chk("beats", 32'(beat_cnt - b0), 32'(TOTAL));
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_in_ready", in_ready, 1'b0);
  endtask

  initial begin
    int a0, d0, idx;
    lines[0] = '0;
    lines[0][31:0]   = 32'h000000FF;
    lines[0][63:32]  = 32'h0000FF00;
    lines[0][95:64]  = 32'h00FF0000;
    lines[0][127:96] = 32'h00FFFFFF;
    lines[0][159:128] = 32'hFF000000;
    lines[1] = {16{32'h55808080}};
    lines[2] = {16{32'h00C83264}};
    lines[3] = {16{32'hAA1E140A}};
    beats[0] = 128'h0000_0000_0000_0000_0000_0000_FF1C_954C;
    beats[1] = {16{8'd128}};
    beats[2] = {16{8'd82}};
    beats[3] = {16{8'd18}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    // Frame A: full throughput, latency and gap-free flush.
    lat_arm = 1'b1;
    run_frame(1'b0, 1'b0);
    chk("latency", 32'(lat_out - lat_acc), 32'd2);
    chk("no_gap", 32'(lat_done - lat_out), 32'(TOTAL));
    lat_arm = 1'b0;

    // Frame B: random backpressure, start pokes mid-stream and in the done cycle.
    run_frame(1'b1, 1'b1);

    // Frame C: asynchronous reset after the third accept.
    a0 = acc_cnt;
    push_exp();
    start = 1'b1; in_valid = 1'b1; in_data = lines[0];
    for (int t = 0; t < 200 && (acc_cnt - a0) < 3; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      idx = acc_cnt - a0;
      in_data = (idx < 4) ? lines[idx] : '0;
    end
    chk("pre_rst_accepts", 32'(acc_cnt - a0), 32'd3);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    d0 = done_cnt;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("arst_idle", busy, 1'b0);

    // Frame D: clean frame after the aborted one.
    run_frame(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
